// File: rtl/trivium_xor_stream.sv
// trivium_xor_stream
//   Consumes keystream blocks from the Trivium core and XORs them word by word
//   onto a data stream. Encrypt and decrypt are the same operation.
//
//   Core side : ks_req (-> Drdy), ks_bsy (<- BSY), ks_vld (<- Dvld), ks_in (<- Dout)
//   Data in   : din / din_vld / din_rdy   (accept on din_vld & din_rdy)
//   Data out  : dout / dout_vld / dout_rdy (one registered output word)
//   Status    : words_left = unused keystream words in the current block
//   Control   : EN=0 freezes the FSM and input acceptance; the output register
//               still drains.
module trivium_xor_stream #(
  parameter  int KS_W   = 4096,
  parameter  int WORD_W = 32,
  localparam int NWORDS = KS_W / WORD_W,
  localparam int WL_W   = $clog2(NWORDS) + 1
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              EN,
  input  logic [KS_W-1:0]   ks_in,
  input  logic              ks_vld,
  input  logic              ks_bsy,
  output logic              ks_req,
  input  logic [WORD_W-1:0] din,
  input  logic              din_vld,
  output logic              din_rdy,
  output logic [WORD_W-1:0] dout,
  output logic              dout_vld,
  input  logic              dout_rdy,
  output logic [WL_W-1:0]   words_left
);

  localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, STREAM} state_t;

  state_t            state, state_nx;
  logic [KS_W-1:0]   buffer;
  logic [IDX_W-1:0]  index;
  logic              accept;
  logic              last_word;

  // The buffer shifts left one word per accept, so the current keystream
  // word is always the top slice: slice 0 (MSB) goes out first.
  assign din_rdy   = (state == STREAM) & EN & (~dout_vld | dout_rdy);
  assign accept    = din_vld & din_rdy;
  assign last_word = (index == IDX_W'(NWORDS - 1));

  always_comb begin
    state_nx = state;
    if (EN) begin
      case (state)
        IDLE:    state_nx = REQ;
        REQ:     if (ks_bsy) state_nx = WAIT;
        WAIT:    if (ks_vld) state_nx = STREAM;
        STREAM:  if (accept && last_word) state_nx = REQ;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state      <= IDLE;
      ks_req     <= 1'b0;
      buffer     <= '0;
      index      <= '0;
      words_left <= '0;
      dout       <= '0;
      dout_vld   <= 1'b0;
    end else begin
      state  <= state_nx;
      // Registered request: high exactly while the FSM sits in REQ, and
      // naturally held while EN=0 since the state is held too.
      ks_req <= (state_nx == REQ);

      if (EN && state == WAIT && ks_vld) begin
        buffer     <= ks_in;
        index      <= '0;
        words_left <= WL_W'(NWORDS);
      end else if (accept) begin
        buffer     <= buffer << WORD_W;
        index      <= index + IDX_W'(1);
        words_left <= words_left - WL_W'(1);
      end

      // Output register drains regardless of FSM state and EN; a drain in
      // the same cycle as an accept simply reloads it.
      if (accept) begin
        dout     <= din ^ buffer[KS_W-1 -: WORD_W];
        dout_vld <= 1'b1;
      end else if (dout_rdy) begin
        dout_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_trivium_xor_stream.sv
// Testbench for trivium_xor_stream: behavioural core model, word-level
// reference (keystream words in streaming order + expected-output queue),
// directed scenarios with randomized data.
module tb_trivium_xor_stream;
  localparam int KS_W   = 4096;
  localparam int WORD_W = 32;
  localparam int NW     = KS_W / WORD_W;

  logic              CLK = 1'b0;
  logic              RSTn = 1'b0;
  logic              EN = 1'b0;
  logic [KS_W-1:0]   ks_in = '0;
  logic              ks_vld = 1'b0;
  logic              ks_bsy = 1'b0;
  logic              ks_req;
  logic [WORD_W-1:0] din = '0;
  logic              din_vld = 1'b0;
  logic              din_rdy;
  logic [WORD_W-1:0] dout;
  logic              dout_vld;
  logic              dout_rdy = 1'b0;
  logic [7:0]        words_left;

  int errs = 0;
  int checks = 0;

  trivium_xor_stream #(.KS_W(KS_W), .WORD_W(WORD_W)) dut (
    .CLK(CLK), .RSTn(RSTn), .EN(EN),
    .ks_in(ks_in), .ks_vld(ks_vld), .ks_bsy(ks_bsy), .ks_req(ks_req),
    .din(din), .din_vld(din_vld), .din_rdy(din_rdy),
    .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy),
    .words_left(words_left)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- core model ----------------
  // Keystream words listed in the order they must be streamed (word 0 first).
  logic [WORD_W-1:0] core_w [NW];
  int nblk = 0;

  initial forever begin
    @(posedge CLK); #1;
    if (ks_req && RSTn) begin
      repeat (2) begin @(posedge CLK); #1; end
      ks_bsy = 1'b1;
      for (int j = 0; j < NW; j++) begin
        if (nblk == 0)      core_w[j] = 32'hA5A5A5A5;
        else if (nblk == 1) core_w[j] = 32'(NW - 1 - j);  // Dout word i = i
        else                core_w[j] = $urandom;
        ks_in[KS_W-1-j*WORD_W -: WORD_W] = core_w[j];
      end
      nblk++;
      repeat (10) begin @(posedge CLK); #1; end
      ks_vld = 1'b1;
      @(posedge CLK); #1;
      ks_vld = 1'b0;
      ks_bsy = 1'b0;
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [WORD_W-1:0] mw [NW];
  int                midx = NW;
  logic [WORD_W-1:0] expq [$];

  initial forever begin
    @(negedge CLK);
    if (!RSTn) begin
      expq.delete();
      midx = NW;
    end else begin
      if (dout_vld && dout_rdy) begin
        if (expq.size() == 0) chk("dout_unexpected", 64'(dout), 64'hx);
        else                  chk("dout", 64'(dout), 64'(expq.pop_front()));
      end
      if (din_vld && din_rdy) begin
        chk("words_left", 64'(words_left), 64'(NW - midx));
        if (midx < NW) expq.push_back(din ^ mw[midx]);
        midx++;
      end
      if (ks_vld) begin
        mw   = core_w;
        midx = 0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge CLK); #1;
  endtask

  // Offer random words until n are accepted or words_left hits stop_wl.
  task automatic stream(input int n, input int stop_wl);
    int acc = 0;
    int g = 0;
    din = $urandom;
    din_vld = 1'b1;
    while (acc < n && g < 2000 && int'(words_left) != stop_wl) begin
      @(negedge CLK);
      if (din_rdy) acc++;
      tick();
      if (acc > 0) din = $urandom;
      g++;
    end
    din_vld = 1'b0;
    if (g >= 2000) chk("stream_timeout", 64'(acc), 64'(n));
  endtask

  task automatic wait_rdy();
    int g = 0;
    do begin
      @(negedge CLK);
      g++;
    end while (!din_rdy && g < 200);
    if (!din_rdy) chk("wait_rdy_timeout", 64'(din_rdy), 64'd1);
    tick();
  endtask

  // ---------------- main ----------------
  initial begin
    int rq, g, acc, seen;
    logic [WORD_W-1:0] d0;

    #2;
    chk("rst_ks_req", 64'(ks_req), 64'd0);
    chk("rst_din_rdy", 64'(din_rdy), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_dout_vld", 64'(dout_vld), 64'd0);
    chk("rst_words_left", 64'(words_left), 64'd0);
    #10 RSTn = 1'b1;
    tick();
    EN = 1'b1;

    // First block: count ks_req cycles until streaming starts.
    rq = 0; g = 0;
    do begin
      @(negedge CLK);
      if (ks_req) rq++;
      g++;
    end while (!din_rdy && g < 100);
    chk("req_cycles", 64'(rq), 64'd3);
    chk("wl_full", 64'(words_left), 64'd128);
    chk("rdy_stream", 64'(din_rdy), 64'd1);
    tick();

    // Two back-to-back words against the A5 block.
    din = 32'h00000000; din_vld = 1'b1; dout_rdy = 1'b1;
    tick();
    din = 32'hFFFFFFFF;
    chk("a5_w0", 64'(dout), 64'hA5A5A5A5);
    chk("a5_vld", 64'(dout_vld), 64'd1);
    chk("a5_wl127", 64'(words_left), 64'd127);
    tick();
    chk("a5_w1", 64'(dout), 64'h5A5A5A5A);
    chk("a5_wl126", 64'(words_left), 64'd126);
    stream(NW - 2, -1);

    // Second block: Dout word i = i, stream zeros.
    wait_rdy();
    din = '0; din_vld = 1'b1;
    for (int j = 0; j < NW; j++) begin
      tick();
      chk("idx_seq", 64'(dout), 64'(NW - 1 - j));
    end
    din_vld = 1'b0;
    chk("req_after_last", 64'(ks_req), 64'd1);
    chk("rdy_after_last", 64'(din_rdy), 64'd0);
    chk("wl_after_last", 64'(words_left), 64'd0);
    seen = 0; g = 0;
    do begin
      @(negedge CLK);
      if (din_rdy) seen = 1;
      g++;
    end while (!ks_vld && g < 100);
    chk("no_prefetch", 64'(seen), 64'd0);
    tick();
    chk("wl_reload", 64'(words_left), 64'd128);

    // Backpressure: dout_rdy low for 5 cycles.
    dout_rdy = 1'b0; din = $urandom; din_vld = 1'b1;
    acc = 0; d0 = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      if (din_rdy) acc++;
      tick();
      if (k == 0) d0 = dout;
      if (acc > 0) din = $urandom;
    end
    chk("bp_accepts", 64'(acc), 64'd1);
    chk("bp_dout_stable", 64'(dout), 64'(d0));
    chk("bp_rdy_low", 64'(din_rdy), 64'd0);
    chk("bp_vld_held", 64'(dout_vld), 64'd1);
    dout_rdy = 1'b1;
    stream(20, -1);

    // EN dropped at words_left = 60.
    stream(NW, 60);
    chk("en_wl_start", 64'(words_left), 64'd60);
    din_vld = 1'b1; EN = 1'b0; acc = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      if (din_rdy) acc++;
      tick();
    end
    chk("en_accepts", 64'(acc), 64'd0);
    chk("en_wl_hold", 64'(words_left), 64'd60);
    chk("en_drained", 64'(dout_vld), 64'd0);
    din_vld = 1'b0; EN = 1'b1;

    // Asynchronous reset mid-stream with a pending output word.
    stream(5, -1);
    dout_rdy = 1'b0; din = $urandom; din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
    #2 RSTn = 1'b0;
    #1;
    chk("arst_ks_req", 64'(ks_req), 64'd0);
    chk("arst_din_rdy", 64'(din_rdy), 64'd0);
    chk("arst_dout", 64'(dout), 64'd0);
    chk("arst_dout_vld", 64'(dout_vld), 64'd0);
    chk("arst_wl", 64'(words_left), 64'd0);
    @(negedge CLK); #2 RSTn = 1'b1;
    wait_rdy();
    din = $urandom; din_vld = 1'b1; dout_rdy = 1'b1;
    d0 = din;
    tick();
    din_vld = 1'b0;
    chk("post_reset_w0", 64'(dout), 64'(d0 ^ core_w[0]));
    stream(10, -1);
    tick(); tick();
    chk("sb_empty", 64'(expq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/trivium_xor_stream.md
Name: trivium_xor_stream

Overview:
- Downstream consumer of the Trivium keystream core.
- Requests one keystream block from the core through the core's Drdy/BSY/Dvld handshake and captures the KS_W-bit block when Dvld rises.
- Streams the block out as WORD_W-bit slices, XORing each slice with an incoming data word under a valid/ready handshake. Encryption and decryption are the same operation.
- Requests the next block automatically once the current one is used up.

Parameters:
- KS_W, 4096, keystream block width; must match the core's Dout width.
- WORD_W, 32, data word width; KS_W must be a multiple of WORD_W.
- NWORDS, KS_W/WORD_W (128), words per block; derived, not overridable.

Ports:
- CLK  in  1  system clock, rising edge.
- RSTn  in  1  asynchronous active-low reset.
- EN  in  1  block enable; 0 freezes the FSM and input acceptance.
- ks_in  in  KS_W  keystream block from the core's Dout.
- ks_vld  in  1  core Dvld.
- ks_bsy  in  1  core BSY.
- ks_req  out  1  to core Drdy; requests a new block.
- din  in  WORD_W  plaintext/ciphertext word.
- din_vld  in  1  din valid.
- din_rdy  out  1  din accepted when din_vld & din_rdy at a rising edge.
- dout  out  WORD_W  din XOR keystream word.
- dout_vld  out  1  dout valid.
- dout_rdy  in  1  downstream ready.
- words_left  out  clog2(NWORDS)+1  unused keystream words in the current block.

Behaviour:
- Reset values (asynchronous on RSTn low): state=IDLE, ks_req=0, din_rdy=0, dout=0, dout_vld=0, words_left=0, index=0, buffer=0.
- FSM states: IDLE, REQ, WAIT, STREAM.
  - IDLE: EN=1 -> REQ.
  - REQ: ks_req=1. Leave for WAIT on the first edge where ks_bsy=1; ks_req drops to 0 in the same transition. ks_req is registered.
  - WAIT: ks_req=0. Capture ks_in on the edge where ks_vld=1, set index=0 and words_left=NWORDS, go to STREAM. A ks_vld seen in any other state is ignored.
  - STREAM: din_rdy = EN & (~dout_vld | dout_rdy) (combinational). On accept: dout <= din ^ buffer[KS_W-1-index*WORD_W -: WORD_W], dout_vld <= 1, index++, words_left--. Word 0 is the MSB slice.
  - Accepting the last word (index=NWORDS-1) -> REQ with words_left=0.
- din_rdy=0 in IDLE, REQ and WAIT. No prefetch.
- Latency: one cycle from din accept to dout_vld. Full throughput of one word per cycle while dout_rdy=1.
- Output register:
  - dout_vld clears on the edge where dout_rdy=1 and no new accept occurs.
  - Simultaneous drain and accept reloads dout with dout_vld held at 1.
  - The output register drains independently of FSM state and EN.
- dout holds its value while dout_vld=1 and dout_rdy=0.
- EN=0: FSM holds its state, din_rdy=0, ks_req holds its value. A pending handshake with the core completes once EN returns.
- A ks_bsy pulse shorter than one cycle is not supported; ks_bsy must be high for at least one edge.
- Reset mid-operation discards the buffer and any pending dout word. After reset a new block must be fetched; keystream words are never reused.
- Bit order is fixed as above. XOR is bitwise, with no carries.

Test Plan:
- Reset, EN=1, core model raises ks_bsy 3 cycles after ks_req and pulses ks_vld 10 cycles later with ks_in = {NWORDS{32'hA5A5A5A5}} -> ks_req high for exactly 3 cycles, then state STREAM with words_left=128 and din_rdy=1.
- din=32'h00000000 then 32'hFFFFFFFF, back-to-back, dout_rdy=1 -> dout=32'hA5A5A5A5 then 32'h5A5A5A5A on consecutive cycles; words_left 128->126.
- ks_in with word i = i (32-bit), stream 128 words of 0 -> dout sequence 127,126,…,0 (MSB slice first); ks_req rises on the cycle after the 128th accept and din_rdy=0 until the next ks_vld.
- dout_rdy held 0 for 5 cycles with din_vld=1 -> exactly one word accepted, dout stable, din_rdy=0. Release -> one word per cycle resumes with no loss or duplication.
- EN dropped for 4 cycles mid-stream at words_left=60 -> no accepts, words_left stays 60. Pending dout drains if dout_rdy=1.
- RSTn asserted asynchronously mid-stream -> all outputs 0 immediately. After release the first dout equals din XOR word 0 of a freshly requested block.
